// File: rtl/debounced_step_counter_if.sv
// Signal bundle between the button/mode sources and the step counter.
// The counter has no valid/ready handshake: inputs are raw asynchronous levels and outputs are registered levels/pulses.
interface debounced_step_counter_if #(
  parameter int WIDTH = 2
);
  logic             btn_up;
  logic             btn_dn;
  logic             auto;
  logic             dir;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             step;
  // Debounce FSM state codes: 0 IDLE, 1 ARM, 2 HELD, 3 DISARM
  logic [1:0]       up_state;
  logic [1:0]       dn_state;

  modport master (
    output btn_up, btn_dn, auto, dir,
    input  q, tc, step, up_state, dn_state
  );

  modport slave (
    input  btn_up, btn_dn, auto, dir,
    output q, tc, step, up_state, dn_state
  );
endinterface

// File: rtl/debounced_step_counter.sv
// Modulo-MODULUS up/down counter driven by two debounced push-buttons or by an
// auto-run prescaler; emits a step pulse on every change and tc on wrap.
module debounced_step_counter #(
  parameter int WIDTH     = 2,
  parameter int MODULUS   = 4,
  parameter int DB_CYCLES = 120000,
  parameter int TICK_DIV  = 12000000
) (
  input  logic                     clk,
  input  logic                     rst,
  debounced_step_counter_if.slave  bus
);

  localparam int DBW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam int PSW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [DBW-1:0]   DB_LAST  = DBW'(DB_CYCLES - 2);
  localparam logic [PSW-1:0]   PRE_LAST = PSW'(TICK_DIV - 1);
  localparam logic [WIDTH-1:0] Q_MAX    = WIDTH'(MODULUS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    HELD   = 2'd2,
    DISARM = 2'd3
  } db_state_t;

  logic [1:0]       up_sy, dn_sy, auto_sy, dir_sy;
  logic [1:0]       lvl;
  logic             auto_s, dir_s;
  db_state_t        st [2];
  logic [DBW-1:0]   dbc [2];
  logic [1:0]       press;
  logic [PSW-1:0]   pre;
  logic             tick;
  logic [WIDTH-1:0] q_r, q_nxt;
  logic             step_r, tc_r;
  logic             inc, dec, chg, wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      up_sy   <= '0;
      dn_sy   <= '0;
      auto_sy <= '0;
      dir_sy  <= '0;
    end else begin
      up_sy   <= {up_sy[0], bus.btn_up};
      dn_sy   <= {dn_sy[0], bus.btn_dn};
      auto_sy <= {auto_sy[0], bus.auto};
      dir_sy  <= {dir_sy[0], bus.dir};
    end
  end

  assign lvl    = {dn_sy[1], up_sy[1]};
  assign auto_s = auto_sy[1];
  assign dir_s  = dir_sy[1];

  // The level was already seen once in IDLE/HELD, so acceptance after
  // DB_CYCLES-1 further stable samples spans DB_CYCLES clock edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        st[i]    <= HELD;
        dbc[i]   <= '0;
        press[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        press[i] <= 1'b0;
        case (st[i])
          IDLE: begin
            if (lvl[i]) begin
              st[i]  <= ARM;
              dbc[i] <= '0;
            end
          end
          ARM: begin
            if (!lvl[i]) begin
              st[i] <= IDLE;
            end else if (dbc[i] == DB_LAST) begin
              st[i]    <= HELD;
              press[i] <= 1'b1;
            end else begin
              dbc[i] <= dbc[i] + 1'b1;
            end
          end
          HELD: begin
            if (!lvl[i]) begin
              st[i]  <= DISARM;
              dbc[i] <= '0;
            end
          end
          DISARM: begin
            if (lvl[i]) begin
              st[i] <= HELD;
            end else if (dbc[i] == DB_LAST) begin
              st[i] <= IDLE;
            end else begin
              dbc[i] <= dbc[i] + 1'b1;
            end
          end
          default: st[i] <= HELD;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre <= '0;
    end else if (!auto_s || pre == PRE_LAST) begin
      pre <= '0;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  assign tick = auto_s && (pre == PRE_LAST);

  always_comb begin
    q_nxt = q_r;
    inc   = 1'b0;
    dec   = 1'b0;
    chg   = 1'b0;
    wrap  = 1'b0;
    if (auto_s) begin
      inc = tick && dir_s;
      dec = tick && !dir_s;
    end else begin
      inc = press[0] && !press[1];
      dec = press[1] && !press[0];
    end
    if (inc) begin
      chg = 1'b1;
      if (q_r == Q_MAX) begin
        q_nxt = '0;
        wrap  = 1'b1;
      end else begin
        q_nxt = q_r + 1'b1;
      end
    end else if (dec) begin
      chg = 1'b1;
      if (q_r == '0) begin
        q_nxt = Q_MAX;
        wrap  = 1'b1;
      end else begin
        q_nxt = q_r - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r    <= '0;
      step_r <= 1'b0;
      tc_r   <= 1'b0;
    end else begin
      q_r    <= q_nxt;
      step_r <= chg;
      tc_r   <= wrap;
    end
  end

  assign bus.q        = q_r;
  assign bus.step     = step_r;
  assign bus.tc       = tc_r;
  assign bus.up_state = st[0];
  assign bus.dn_state = st[1];

endmodule

// File: tb/tb_debounced_step_counter.sv
// Directed bench for debounced_step_counter with DB_CYCLES=4, TICK_DIV=8, MODULUS=4.
module tb_debounced_step_counter;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  debounced_step_counter_if #(.WIDTH(2)) bus ();

  debounced_step_counter #(
    .WIDTH(2), .MODULUS(4), .DB_CYCLES(4), .TICK_DIV(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    repeat (10) cyc();
  endtask

  // Raw press held 10 cycles then released; the change lands 7 edges after the rise.
  task automatic drive_press(input logic up, input logic dn, output logic [1:0] q7,
                             output logic s6, output logic s7, output logic t7,
                             output int extra);
    bus.btn_up = up;
    bus.btn_dn = dn;
    extra = 0;
    s6 = 1'b0; s7 = 1'b0; t7 = 1'b0; q7 = 2'd0;
    for (int e = 1; e <= 20; e++) begin
      cyc();
      if (e == 6) s6 = bus.step;
      if (e == 7) begin
        q7 = bus.q;
        s7 = bus.step;
        t7 = bus.tc;
      end
      if (e > 7 && bus.step) extra++;
      if (e == 10) begin
        bus.btn_up = 1'b0;
        bus.btn_dn = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.btn_up = 1'b0; bus.btn_dn = 1'b0; bus.auto = 1'b0; bus.dir = 1'b0;
    #2;
    checks++;
    if (bus.q !== 2'd0 || bus.tc !== 1'b0 || bus.step !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: q=%0d tc=%b step=%b, expected q=0 tc=0 step=0", bus.q, bus.tc, bus.step);
    end
    cyc();
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      checks++;
      if (bus.step !== 1'b0 || bus.q !== 2'd0) begin
        errors++;
        $display("FAIL reset_idle cyc %0d: q=%0d step=%b, expected q=0 step=0", i, bus.q, bus.step);
      end
    end
  endtask

  task automatic test_single_press();
    logic [1:0] q7; logic s6, s7, t7; int extra;
    drive_press(1'b1, 1'b0, q7, s6, s7, t7, extra);
    checks++;
    if (s6 !== 1'b0) begin
      errors++;
      $display("FAIL press_early: step=%b at edge 6, expected 0", s6);
    end
    checks++;
    if (q7 !== 2'd1 || s7 !== 1'b1 || t7 !== 1'b0) begin
      errors++;
      $display("FAIL press_latency: q=%0d step=%b tc=%b at edge 7, expected q=1 step=1 tc=0", q7, s7, t7);
    end
    checks++;
    if (extra !== 0 || bus.q !== 2'd1) begin
      errors++;
      $display("FAIL press_no_repeat: extra steps=%0d q=%0d, expected 0 and q=1", extra, bus.q);
    end
  endtask

  task automatic test_bounce();
    int steps = 0;
    for (int i = 0; i < 20; i++) begin
      bus.btn_up = ((i / 2) % 2 == 0);
      cyc();
      if (bus.step) steps++;
    end
    bus.btn_up = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (bus.step) steps++;
    end
    checks++;
    if (steps !== 0 || bus.q !== 2'd1) begin
      errors++;
      $display("FAIL bounce: steps=%0d q=%0d, expected steps=0 q=1", steps, bus.q);
    end
  endtask

  task automatic test_wrap();
    logic [1:0] q7; logic s6, s7, t7; int extra;
    logic [1:0] exp_seq [4];
    exp_seq = '{2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    drive_press(1'b0, 1'b1, q7, s6, s7, t7, extra);
    checks++;
    if (q7 !== 2'd3 || s7 !== 1'b1 || t7 !== 1'b1 || s6 !== 1'b0 || extra !== 0) begin
      errors++;
      $display("FAIL wrap_down: q=%0d step=%b tc=%b pre=%b extra=%0d, expected q=3 step=1 tc=1 pre=0 extra=0",
               q7, s7, t7, s6, extra);
    end
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_press(1'b1, 1'b0, q7, s6, s7, t7, extra);
      checks++;
      if (q7 !== exp_seq[i] || s7 !== 1'b1 || t7 !== (i == 3) || extra !== 0) begin
        errors++;
        $display("FAIL wrap_up press %0d: q=%0d step=%b tc=%b extra=%0d, expected q=%0d step=1 tc=%0d extra=0",
                 i, q7, s7, t7, extra, exp_seq[i], (i == 3));
      end
    end
  endtask

  task automatic test_both_and_held();
    logic [1:0] q7; logic s6, s7, t7; int extra;
    int steps = 0;
    drive_press(1'b1, 1'b1, q7, s6, s7, t7, extra);
    checks++;
    if (q7 !== 2'd0 || s7 !== 1'b0 || extra !== 0) begin
      errors++;
      $display("FAIL both_press: q=%0d step=%b extra=%0d, expected q=0 step=0 extra=0", q7, s7, extra);
    end
    bus.btn_up = 1'b1;
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (bus.step) steps++;
    end
    checks++;
    if (steps !== 0 || bus.q !== 2'd0) begin
      errors++;
      $display("FAIL held_through_reset: steps=%0d q=%0d, expected 0 and q=0", steps, bus.q);
    end
    bus.btn_up = 1'b0;
    repeat (10) cyc();
    drive_press(1'b1, 1'b0, q7, s6, s7, t7, extra);
    checks++;
    if (q7 !== 2'd1 || s7 !== 1'b1) begin
      errors++;
      $display("FAIL repress_after_release: q=%0d step=%b, expected q=1 step=1", q7, s7);
    end
  endtask

  task automatic test_auto();
    logic [1:0] exp_q [$];
    logic       exp_tc [$];
    logic       exp_step;
    logic [1:0] eq;
    logic       et;
    int         steps = 0;
    do_reset();
    exp_q  = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd0, 2'd3};
    exp_tc = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    bus.auto = 1'b1;
    bus.dir  = 1'b1;
    for (int k = 1; k <= 58; k++) begin
      cyc();
      exp_step = (k >= 10) && ((k - 10) % 8 == 0);
      checks++;
      if (bus.step !== exp_step) begin
        errors++;
        $display("FAIL auto_step edge %0d: step=%b, expected %b", k, bus.step, exp_step);
      end
      if (exp_step && exp_q.size() > 0) begin
        eq = exp_q.pop_front();
        et = exp_tc.pop_front();
        checks++;
        if (bus.q !== eq || bus.tc !== et) begin
          errors++;
          $display("FAIL auto_value edge %0d: q=%0d tc=%b, expected q=%0d tc=%b", k, bus.q, bus.tc, eq, et);
        end
      end
      if (k == 4)  bus.btn_dn = 1'b1;
      if (k == 20) bus.btn_dn = 1'b0;
      if (k == 42) bus.dir = 1'b0;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL auto_count: %0d expected steps not seen, expected 0 left", exp_q.size());
    end
    bus.auto = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (bus.step) steps++;
    end
    checks++;
    if (steps !== 0 || bus.q !== 2'd3) begin
      errors++;
      $display("FAIL auto_off: steps=%0d q=%0d, expected 0 and q=3", steps, bus.q);
    end
  endtask

  task automatic test_reset_mid();
    int steps = 0;
    bus.auto   = 1'b1;
    bus.dir    = 1'b1;
    bus.btn_up = 1'b1;
    repeat (5) cyc();
    checks++;
    if (bus.q !== 2'd3) begin
      errors++;
      $display("FAIL mid_setup: q=%0d, expected 3", bus.q);
    end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.q !== 2'd0 || bus.tc !== 1'b0 || bus.step !== 1'b0) begin
      errors++;
      $display("FAIL mid_async_reset: q=%0d tc=%b step=%b, expected q=0 tc=0 step=0", bus.q, bus.tc, bus.step);
    end
    bus.auto = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (bus.step || bus.q !== 2'd0) steps++;
    end
    checks++;
    if (steps !== 0) begin
      errors++;
      $display("FAIL mid_after_release: %0d cycles with step or q!=0, expected 0", steps);
    end
    bus.btn_up = 1'b0;
    repeat (10) cyc();
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_wrap();
    test_both_and_held();
    test_auto();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
